// File: rtl/axis_packet_capture_if.sv
// AXI-Stream beat channel shared by the packet source and the capture sink.
// Latency: none (wires only).
// Backpressure: tready from the slave qualifies every tvalid beat.
// Signals: tvalid/tready handshake, tdata beat payload, tstrb byte strobes,
//   tlast end-of-packet marker.
interface axis_packet_capture_if #(
  parameter int DATA_W = 192
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic              tlast;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/axis_packet_capture.sv
// Captures one armed AXI-Stream packet into a buffer and checks tlast framing.
// Latency: beat written on the accepting edge; rd_data is 1 cycle after rd_addr.
// Backpressure: tready high only while CAPTURE/DROP; stalls held indefinitely.
// Ports: s00_axis_aclk/s00_axis_aresetn (sync active-low), s00_axis (AXIS slave),
//   arm (start pulse), busy/done status, beats_captured, err_short/err_long,
//   rd_addr/rd_data synchronous read port.
// Optional: define CAPTURE_STATS_EN to add saturating pkt_count/err_count outputs.
module axis_packet_capture #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 192,
  parameter int PACKET_COUNT           = 512,
  localparam int CNT_W = $clog2(PACKET_COUNT + 1),
  localparam int AW    = $clog2(PACKET_COUNT)
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  axis_packet_capture_if.slave              s00_axis,
  input  logic                              arm,
  output logic                              busy,
  output logic                              done,
  output logic [CNT_W-1:0]                  beats_captured,
  output logic                              err_short,
  output logic                              err_long,
  input  logic [AW-1:0]                     rd_addr,
`ifdef CAPTURE_STATS_EN
  output logic [15:0]                       pkt_count,
  output logic [15:0]                       err_count,
`endif
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DROP, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(PACKET_COUNT - 1);

  state_t                            r_state;
  logic                              r_tready;
  logic                              r_busy;
  logic                              r_done;
  logic                              r_err_short;
  logic                              r_err_long;
  logic [CNT_W-1:0]                  r_beats;
  logic [AW-1:0]                     r_wr_ptr;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] r_rd_data;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] r_mem [PACKET_COUNT];

  logic w_accept;
  logic w_wr_en;
  logic w_enter_done;
  logic w_enter_err;
  logic w_unused_tstrb;

  // r_tready mirrors CAPTURE|DROP, so it alone qualifies the handshake.
  assign w_accept     = s00_axis.tvalid & r_tready;
  assign w_wr_en      = w_accept & (r_state == S_CAPTURE);
  assign w_enter_done = w_accept & s00_axis.tlast &
                        ((r_state == S_CAPTURE) | (r_state == S_DROP));
  // Leaving DROP always means the packet was long; leaving CAPTURE early means short.
  assign w_enter_err  = (r_state == S_DROP) | (r_wr_ptr != LAST_PTR);
  assign w_unused_tstrb = ^s00_axis.tstrb;

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      r_state     <= S_IDLE;
      r_tready    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_beats     <= '0;
      r_wr_ptr    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            r_state     <= S_CAPTURE;
            r_tready    <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_beats     <= '0;
            r_wr_ptr    <= '0;
          end
        end
        S_CAPTURE: begin
          if (w_accept) begin
            r_beats <= CNT_W'(r_wr_ptr) + CNT_W'(1);
            if (r_wr_ptr == LAST_PTR) begin
              // Pointer parks on the last slot; it never wraps.
              if (s00_axis.tlast) begin
                r_state  <= S_DONE;
                r_tready <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
              end else begin
                r_state    <= S_DROP;
                r_err_long <= 1'b1;
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
              if (s00_axis.tlast) begin
                r_state     <= S_DONE;
                r_tready    <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_err_short <= 1'b1;
              end
            end
          end
        end
        S_DROP: begin
          if (w_accept && s00_axis.tlast) begin
            r_state  <= S_DONE;
            r_tready <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer kept reset-free so it maps onto block RAM.
  always_ff @(posedge s00_axis_aclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= s00_axis.tdata;
    end
  end

  // Read-before-write: same-address collision returns the old word.
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

`ifdef CAPTURE_STATS_EN
  logic [15:0] r_pkt_count;
  logic [15:0] r_err_count;

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else if (w_enter_done) begin
      if (r_pkt_count != 16'hFFFF) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      if (w_enter_err && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign pkt_count = r_pkt_count;
  assign err_count = r_err_count;
`endif

  assign s00_axis.tready = r_tready;
  assign busy            = r_busy;
  assign done            = r_done;
  assign beats_captured  = r_beats;
  assign err_short       = r_err_short;
  assign err_long        = r_err_long;
  assign rd_data         = r_rd_data;

endmodule

// File: tb/tb_axis_packet_capture.sv
module tb_axis_packet_capture;
  localparam int W     = 192;
  localparam int PC    = 512;
  localparam int CNT_W = $clog2(PC + 1);
  localparam int AW    = $clog2(PC);

  logic             clk      = 1'b0;
  logic             aresetn  = 1'b0;
  logic             arm      = 1'b0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] beats_captured;
  logic             err_short;
  logic             err_long;
  logic [AW-1:0]    rd_addr  = '0;
  logic [W-1:0]     rd_data;
`ifdef CAPTURE_STATS_EN
  logic [15:0]      pkt_count;
  logic [15:0]      err_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  axis_packet_capture_if #(.DATA_W(W)) axis ();

  axis_packet_capture #(
    .C_S00_AXIS_TDATA_WIDTH(W),
    .PACKET_COUNT(PC)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(aresetn),
    .s00_axis        (axis),
    .arm             (arm),
    .busy            (busy),
    .done            (done),
    .beats_captured  (beats_captured),
    .err_short       (err_short),
    .err_long        (err_long),
    .rd_addr         (rd_addr),
`ifdef CAPTURE_STATS_EN
    .pkt_count       (pkt_count),
    .err_count       (err_count),
`endif
    .rd_data         (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string name;
    int    n_beats;
    int    tlast_at;
    int    arm_at;
    int    exp_cnt;
    bit    exp_short;
    bit    exp_long;
    int    rd_a;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Beat i carries data i; tlast on beat number tlast_at (1-based), arm pulsed with beat arm_at.
  task automatic send_packet(input int n, input int tlast_at, input int arm_at, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      int budget;
      bit acc;
      axis.tvalid = 1'b1;
      axis.tdata  = W'(i);
      axis.tstrb  = '1;
      axis.tlast  = (i == tlast_at - 1);
      arm         = (i == arm_at);
      budget = 0;
      acc    = 1'b0;
      while (!acc && budget < 20) begin
        acc = axis.tready;
        if (!acc) stalls++;
        tick();
        arm = 1'b0;
        budget++;
      end
      if (!acc) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat_accept: beat %0d not accepted within 20 cycles", i);
        break;
      end
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    arm         = 1'b0;
  endtask

  initial begin
    int stalls;

    vecs[0] = '{name: "full",    n_beats: 512, tlast_at: 512, arm_at: -1, exp_cnt: 512, exp_short: 0, exp_long: 0, rd_a: 7};
    vecs[1] = '{name: "short",   n_beats: 100, tlast_at: 100, arm_at: -1, exp_cnt: 100, exp_short: 1, exp_long: 0, rd_a: 99};
    vecs[2] = '{name: "long",    n_beats: 600, tlast_at: 600, arm_at: -1, exp_cnt: 512, exp_short: 0, exp_long: 1, rd_a: 511};
    vecs[3] = '{name: "arm_mid", n_beats: 512, tlast_at: 512, arm_at: 50, exp_cnt: 512, exp_short: 0, exp_long: 0, rd_a: 300};

    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tstrb  = '0;
    axis.tlast  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_tready", W'(axis.tready), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_beats", W'(beats_captured), W'(0));
    check("rst_err_short", W'(err_short), W'(0));
    check("rst_err_long", W'(err_long), W'(0));
    check("rst_rd_data", rd_data, W'(0));
    aresetn = 1'b1;
    tick();

    // tvalid in IDLE is ignored
    axis.tvalid = 1'b1;
    axis.tlast  = 1'b1;
    axis.tdata  = W'(16'hBEEF);
    repeat (3) begin
      tick();
      check("idle_tready", W'(axis.tready), W'(0));
      check("idle_busy", W'(busy), W'(0));
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    check("idle_done", W'(done), W'(0));

    // Table-driven packets
    for (int v = 0; v < 4; v++) begin
      do_arm();
      check({vecs[v].name, "_arm_busy"}, W'(busy), W'(1));
      check({vecs[v].name, "_arm_tready"}, W'(axis.tready), W'(1));
      check({vecs[v].name, "_arm_done"}, W'(done), W'(0));
      check({vecs[v].name, "_arm_beats"}, W'(beats_captured), W'(0));
      check({vecs[v].name, "_arm_errs"}, W'({err_short, err_long}), W'(0));
      send_packet(vecs[v].n_beats, vecs[v].tlast_at, vecs[v].arm_at, stalls);
      check({vecs[v].name, "_tready_stalls"}, W'(stalls), W'(0));
      check({vecs[v].name, "_done"}, W'(done), W'(1));
      check({vecs[v].name, "_busy"}, W'(busy), W'(0));
      check({vecs[v].name, "_tready_done"}, W'(axis.tready), W'(0));
      check({vecs[v].name, "_beats"}, W'(beats_captured), W'(vecs[v].exp_cnt));
      check({vecs[v].name, "_err_short"}, W'(err_short), W'(vecs[v].exp_short));
      check({vecs[v].name, "_err_long"}, W'(err_long), W'(vecs[v].exp_long));
      rd_addr = AW'(vecs[v].rd_a);
      tick();
      check({vecs[v].name, "_rd_data"}, rd_data, W'(vecs[v].rd_a));
      rd_addr = '0;
      tick();
      check({vecs[v].name, "_rd_data0"}, rd_data, W'(0));
    end

`ifdef CAPTURE_STATS_EN
    check("stats_pkt_count", W'(pkt_count), W'(4));
    check("stats_err_count", W'(err_count), W'(2));
`endif

    // tvalid in DONE: no acceptance, no write, outputs frozen
    axis.tvalid = 1'b1;
    axis.tlast  = 1'b1;
    axis.tdata  = '1;
    repeat (3) begin
      tick();
      check("done_tready", W'(axis.tready), W'(0));
      check("done_hold", W'(done), W'(1));
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    check("done_beats_frozen", W'(beats_captured), W'(512));
    rd_addr = AW'(511);
    tick();
    check("done_no_write", rd_data, W'(511));

    // Reset mid-capture, then a clean recapture
    do_arm();
    send_packet(300, -1, -1, stalls);
    check("mid_beats", W'(beats_captured), W'(300));
    check("mid_busy", W'(busy), W'(1));
    axis.tvalid = 1'b1;
    axis.tdata  = W'(999);
    aresetn     = 1'b0;
    tick();
    check("abort_busy", W'(busy), W'(0));
    check("abort_tready", W'(axis.tready), W'(0));
    check("abort_beats", W'(beats_captured), W'(0));
    axis.tvalid = 1'b0;
    aresetn     = 1'b1;
    tick();
    tick();
    check("abort_no_done", W'(done), W'(0));
    check("abort_idle_tready", W'(axis.tready), W'(0));
    do_arm();
    send_packet(512, 512, -1, stalls);
    check("rearm_done", W'(done), W'(1));
    check("rearm_beats", W'(beats_captured), W'(512));
    check("rearm_errs", W'({err_short, err_long}), W'(0));
    rd_addr = AW'(300);
    tick();
    check("rearm_rd300", rd_data, W'(300));
`ifdef CAPTURE_STATS_EN
    check("rearm_pkt_count", W'(pkt_count), W'(1));
    check("rearm_err_count", W'(err_count), W'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
